// File: rtl/register_file_dump_reader_pkg.sv
// Shared types and default widths for the register-file dump reader.
// The state encoding and word sizes here must stay in step with the register file.
package register_file_dump_reader_pkg;

    localparam int WL_DEFAULT               = 32;
    localparam int READ_INPUT_WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } dump_state_e;

endpackage

// File: rtl/register_file_dump_reader.sv
// Walks a wrap-capable register address range through one read port and
// streams each captured word, with its address, over a valid/ready handshake.
module register_file_dump_reader
    import register_file_dump_reader_pkg::*;
#(
    parameter int WL               = WL_DEFAULT,
    parameter int READ_INPUT_WIDTH = READ_INPUT_WIDTH_DEFAULT,
    parameter int MEMORY_DEPTH     = 32
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        Dump_Start,
    input  logic [READ_INPUT_WIDTH-1:0] Dump_First_Addr,
    input  logic [READ_INPUT_WIDTH-1:0] Dump_Last_Addr,
    output logic [READ_INPUT_WIDTH-1:0] RF_Read_Address,
    input  logic [WL-1:0]               RF_Read_Data,
    output logic                        Out_Valid,
    input  logic                        Out_Ready,
    output logic [WL-1:0]               Out_Data,
    output logic [READ_INPUT_WIDTH-1:0] Out_Addr,
    output logic                        Out_Last,
    output logic                        Dump_Busy,
    output logic                        Dump_Done
);

    dump_state_e                 state;
    logic [READ_INPUT_WIDTH-1:0] cur_addr;
    logic [READ_INPUT_WIDTH-1:0] last_addr;
    logic [READ_INPUT_WIDTH-1:0] next_addr;

    always_comb begin
        next_addr = cur_addr + 1'b1;
        if (cur_addr == READ_INPUT_WIDTH'(MEMORY_DEPTH - 1))
            next_addr = '0;
    end

    // RF_Read_Address is loaded one step ahead so it is already valid during READ.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state           <= IDLE;
            cur_addr        <= '0;
            last_addr       <= '0;
            RF_Read_Address <= '0;
            Out_Valid       <= 1'b0;
            Out_Data        <= '0;
            Out_Addr        <= '0;
            Out_Last        <= 1'b0;
            Dump_Busy       <= 1'b0;
            Dump_Done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Dump_Start) begin
                        cur_addr        <= Dump_First_Addr;
                        last_addr       <= Dump_Last_Addr;
                        RF_Read_Address <= Dump_First_Addr;
                        Dump_Busy       <= 1'b1;
                        state           <= READ;
                    end
                end
                READ: begin
                    Out_Data  <= RF_Read_Data;
                    Out_Addr  <= cur_addr;
                    Out_Last  <= (cur_addr == last_addr);
                    Out_Valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        if (Out_Last) begin
                            Dump_Done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cur_addr        <= next_addr;
                            RF_Read_Address <= next_addr;
                            state           <= READ;
                        end
                    end
                end
                DONE: begin
                    Dump_Done <= 1'b0;
                    Dump_Busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_dump_reader.sv
// Randomized bench for the dump reader: a behavioural register file feeds the DUT and
// each dump is checked against an address/data sequence derived from the range rules.
module tb_register_file_dump_reader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Dump_Start = 1'b0;
    logic [4:0]  Dump_First_Addr = '0;
    logic [4:0]  Dump_Last_Addr = '0;
    logic [4:0]  RF_Read_Address;
    logic [31:0] RF_Read_Data;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [31:0] Out_Data;
    logic [4:0]  Out_Addr;
    logic        Out_Last;
    logic        Dump_Busy;
    logic        Dump_Done;

    logic [31:0] regs [32];
    int total = 0;
    int bad   = 0;

    assign RF_Read_Data = regs[RF_Read_Address];

    always #5 CLK = ~CLK;

    register_file_dump_reader #(
        .WL(32),
        .READ_INPUT_WIDTH(5),
        .MEMORY_DEPTH(32)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .Dump_Start(Dump_Start),
        .Dump_First_Addr(Dump_First_Addr),
        .Dump_Last_Addr(Dump_Last_Addr),
        .RF_Read_Address(RF_Read_Address),
        .RF_Read_Data(RF_Read_Data),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Out_Data(Out_Data),
        .Out_Addr(Out_Addr),
        .Out_Last(Out_Last),
        .Dump_Busy(Dump_Busy),
        .Dump_Done(Dump_Done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rfaddr"}, RF_Read_Address, 0);
        check_val({tag, "_valid"},  Out_Valid, 0);
        check_val({tag, "_data"},   Out_Data, 0);
        check_val({tag, "_addr"},   Out_Addr, 0);
        check_val({tag, "_last"},   Out_Last, 0);
        check_val({tag, "_busy"},   Dump_Busy, 0);
        check_val({tag, "_done"},   Dump_Done, 0);
    endtask

    // mode 0: ready tied high, 1: random ready, 2: stall stall_cycles then ready
    task automatic run_dump(input int first, input int last, input int mode,
                            input int stall_cycles, input bit mid_start);
        int          count;
        logic [31:0] snap [32];
        int          got_n = 0;
        int          wait_n = 0;
        int          cyc = 0;
        int          stall_left = stall_cycles;
        bit          holding = 0;
        bit          pulsed = 0;
        bit          finished = 0;
        bit          r;
        logic [31:0] held_d = '0;
        logic [31:0] held_a = '0;
        int          exp_addr;

        count = (last - first + 32) % 32 + 1;
        for (int i = 0; i < 32; i++) snap[i] = regs[i];

        Dump_First_Addr = 5'(first);
        Dump_Last_Addr  = 5'(last);
        Dump_Start      = 1'b1;
        Out_Ready       = (mode == 0);
        @(negedge CLK);
        wait_n++;
        while (!finished && cyc < 3000) begin
            Dump_Start = 1'b0;
            if (got_n == count) begin
                check_val("done_pulse", Dump_Done, 1);
                check_val("done_busy",  Dump_Busy, 1);
                check_val("done_valid", Out_Valid, 0);
                if (mid_start) begin
                    Dump_First_Addr = 5'd12;
                    Dump_Last_Addr  = 5'd14;
                    Dump_Start      = 1'b1;
                end
                @(negedge CLK);
                Dump_Start = 1'b0;
                check_val("done_clear", Dump_Done, 0);
                check_val("idle_busy",  Dump_Busy, 0);
                @(negedge CLK);
                check_val("start_in_done_ignored", Dump_Busy, 0);
                finished = 1;
            end else begin
                if (Out_Valid && holding) begin
                    check_val("hold_data", Out_Data, held_d);
                    check_val("hold_addr", Out_Addr, held_a);
                end else if (Out_Valid) begin
                    check_val("latency", wait_n, 2);
                    holding = 1;
                    held_d  = Out_Data;
                    held_a  = Out_Addr;
                end
                if (mid_start && !pulsed && got_n == 1) begin
                    Dump_First_Addr = 5'(first + 9);
                    Dump_Last_Addr  = 5'(first + 9);
                    Dump_Start      = 1'b1;
                    pulsed          = 1;
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom % 2);
                    default: begin
                        r = 1'b1;
                        if (Out_Valid && stall_left > 0) begin
                            r = 1'b0;
                            if (stall_left == 5) regs[first] = 32'hDEAD_BEEF;
                            stall_left--;
                        end
                    end
                endcase
                Out_Ready = r;
                if (Out_Valid && r) begin
                    exp_addr = (first + got_n) % 32;
                    check_val("word_addr", Out_Addr, exp_addr);
                    check_val("word_data", Out_Data, snap[exp_addr]);
                    check_val("word_last", Out_Last, (got_n == count - 1));
                    got_n++;
                    holding = 0;
                    wait_n  = 0;
                end
                @(negedge CLK);
                wait_n++;
                cyc++;
            end
        end
        Out_Ready  = 1'b0;
        Dump_Start = 1'b0;
        if (!finished) check_val("dump_timeout", 0, 1);
        check_val("word_count", got_n, count);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_val("idle_busy0", Dump_Busy, 0);

        run_dump(0, 31, 0, 0, 0);
        run_dump(30, 1, 0, 0, 0);
        run_dump(5, 5, 2, 10, 0);
        regs[5] = 32'hA000_0005;
        run_dump(3, 10, 0, 0, 1);
        run_dump(0, 31, 1, 0, 0);
        for (int k = 0; k < 6; k++)
            run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1, 0, k % 2);

        // Asynchronous reset while a word is being presented.
        Dump_First_Addr = 5'd0;
        Dump_Last_Addr  = 5'd31;
        Out_Ready       = 1'b0;
        Dump_Start      = 1'b1;
        @(negedge CLK);
        Dump_Start = 1'b0;
        @(negedge CLK);
        check_val("pre_reset_valid", Out_Valid, 1);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 check_all_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_val("reset_no_done", Dump_Done, 0);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        run_dump(2, 3, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
